mux_scan_n: RTL and testbench
=============================

# mux_scan_n

Parametrised, registered N-channel W-bit multiplexer with manual and auto-scan modes, successor to the 8-bit 8-to-1 combinational selector. In manual mode it registers the externally selected channel. In scan mode it rotates through enabled channels at a programmable dwell period. It sits between the CPU/peripheral data buses and the display/debug output path; the seven-segment scanner drives its `o`/`o_sel` pair.

## Interface
- `CH`, 8, number of input channels (2..16).
- `W`, 8, channel data width in bits.
- `SW`, 3, select width; must equal `$clog2(CH)`.
- `DIV_W`, 16, dwell counter width.

- `clk` input 1: system clock; all state changes on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `mode` input 1: 0 = manual select, 1 = auto scan.
- `sel_in` input SW: manual channel select.
- `en_mask` input CH: per-channel enable; bit i enables channel i.
- `dwell` input DIV_W: scan period minus one, in clk cycles.
- `hold` input 1: freezes the scan divider and pointer.
- `din` input CH*W: packed channel data; channel i occupies `din[i*W +: W]`.
- `o` output W: selected data, registered.
- `o_sel` output SW: index of the channel currently presented on `o`, registered.
- `o_valid` output 1: `o` carries an enabled channel.
- `tick` output 1: single-cycle pulse in the cycle `o_sel` advances in scan mode.

## Operation
- Reset (`rst_n`=0 at a clk edge): `o`=0, `o_sel`=0, `o_valid`=0, `tick`=0, pointer `ptr`=0, divider `cnt`=0. Reset overrides every other input, including mid-dwell.
- **Manual mode (`mode`=0):**
  - Each cycle: `ptr` <= `sel_in`; `cnt` <= 0; `tick` <= 0.
  - If `sel_in` < CH and `en_mask[sel_in]`: `o` <= channel `sel_in`, `o_valid` <= 1.
  - Otherwise: `o` <= 0, `o_valid` <= 0.
  - `o_sel` <= `sel_in` in both cases.
- **Scan mode (`mode`=1):**
  - Divider: if `hold`=0 and `cnt` >= `dwell`, the cycle is an expiry and `cnt` <= 0. Otherwise, if `hold`=0, `cnt` <= `cnt`+1. If `hold`=1, `cnt` holds. The >= compare means a dwell reduced below the current count forces expiry on the next cycle.
  - On expiry: `ptr` <= the next enabled channel, searched circularly from `ptr`+1 and wrapping at CH-1 -> 0. Channels >= CH are never visited. If the only enabled channel is `ptr`, it stays. `tick` <= 1 on every expiry where `ptr` changes, else 0.
  - `en_mask` all zero: `ptr` holds, `tick`=0, `o`=0, `o_valid`=0.
  - Each cycle: `o` <= channel `ptr` (the value after update) if `en_mask[ptr]`, else 0. `o_valid` <= `en_mask[ptr]`. `o_sel` <= `ptr`.
  - If the mask disables the current channel mid-dwell, `o_valid` drops next cycle and the pointer moves at the next expiry.
- **Mode switching:**
  - Manual -> scan: scanning starts from the last `sel_in` with `cnt`=0.
  - Scan -> manual: takes effect the next cycle; `tick` is forced to 0.
- `dwell`=0: expiry every cycle, so the channel advances every clk.
- `hold` is ignored in manual mode.

## Timing
- Latency is 1 cycle from `din`/`sel_in`/`en_mask` to `o`/`o_valid`/`o_sel`. There is no combinational path from inputs to outputs.
- Scan period is `dwell`+1 cycles per channel when `hold`=0.
- `tick`, `o_sel` change and `o` switching occur in the same output cycle.
- `din` changes on the current channel appear on `o` 1 cycle later, including during `hold`.
- The next-enabled-channel search is a single-cycle priority search over CH bits. No multicycle path is allowed.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles with `din` all 0xFF, then release -> `o`=0x00, `o_sel`=0, `o_valid`=0, `tick`=0 during reset.
- Manual: CH=8, W=8, `din` channel i = 0x10+i, `en_mask`=0xFF, `sel_in`=5 -> next cycle `o`=0x15, `o_sel`=5, `o_valid`=1. Clear `en_mask[5]` -> `o`=0x00, `o_valid`=0.
- Scan wrap: `mode`=1, `dwell`=3, `en_mask`=0xFF, starting from `sel_in`=6 -> `o_sel` sequence 6,7,0,1, each held for 4 cycles, with a `tick` pulse at each change and `o`=0x16,0x17,0x10,0x11.
- Mask skip: `en_mask`=0b1000_0101, `dwell`=0 -> `o_sel` cycles 0,2,7,0,2,... one per cycle, and `o_valid` stays 1. Set `en_mask`=0 -> `o_valid`=0, `tick`=0, `o_sel` frozen.
- Hold and dwell shrink: assert `hold` for 10 cycles mid-dwell (`dwell`=100) -> `o_sel` unchanged and no `tick`. Release `hold` with `cnt`=50 and set `dwell`=20 -> advance on the next cycle.
- Reset mid-scan: at `o_sel`=3 with `cnt`=2, pulse `rst_n`=0 for 1 cycle -> `o_sel`=0, `cnt` restarts at 0, and the first advance comes `dwell`+1 cycles after release.

Source files
------------

// File: rtl/mux_scan_n.sv
// Registered N-channel W-bit multiplexer: manual channel select, or auto-scan across enabled
// channels with a programmable dwell period, hold and a tick pulse on every pointer advance.
module mux_scan_n #(
    parameter int unsigned CH    = 8,
    parameter int unsigned W     = 8,
    parameter int unsigned SW    = 3,
    parameter int unsigned DIV_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SW-1:0]     sel_in,
    input  logic [CH-1:0]     en_mask,
    input  logic [DIV_W-1:0]  dwell,
    input  logic              hold,
    input  logic [CH*W-1:0]   din,
    output logic [W-1:0]      o,
    output logic [SW-1:0]     o_sel,
    output logic              o_valid,
    output logic              tick
);

    logic [SW-1:0]    ptr_q, ptr_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     o_q, o_d;
    logic             o_valid_q, o_valid_d;
    logic             tick_q, tick_d;

    logic             expire;
    logic             found;
    logic [SW-1:0]    nxt;
    int unsigned      cand;

    // Indices at or above CH read as disabled.
    function automatic logic ch_en(input logic [SW-1:0] idx, input logic [CH-1:0] mask);
        ch_en = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (idx == SW'(i)) ch_en = mask[i];
        end
    endfunction

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        expire = 1'b0;
        found  = 1'b0;
        nxt    = ptr_q;
        cand   = 0;

        // Circular priority search from ptr+1; ptr itself is the last candidate.
        for (int unsigned k = 1; k <= CH; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= CH) cand = cand - CH;
            if (cand >= CH) cand = cand - CH;
            if (!found && ch_en(cand[SW-1:0], en_mask)) begin
                found = 1'b1;
                nxt   = cand[SW-1:0];
            end
        end

        if (!mode) begin
            ptr_d = sel_in;
            cnt_d = '0;
        end else begin
            expire = !hold && (cnt_q >= dwell);
            if (!hold) cnt_d = expire ? '0 : cnt_q + DIV_W'(1);
            if (expire && found) begin
                ptr_d  = nxt;
                tick_d = (nxt != ptr_q);
            end
        end

        o_valid_d = ch_en(ptr_d, en_mask);
        o_d       = '0;
        for (int i = 0; i < CH; i++) begin
            if (o_valid_d && (ptr_d == SW'(i))) o_d = din[i*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            tick_q    <= tick_d;
        end
    end

    assign o       = o_q;
    assign o_sel   = ptr_q;
    assign o_valid = o_valid_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: stimulus pushes per-cycle expectations, a monitor pops and
// compares them one clock later.
module tb_mux_scan_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [2:0]  sel_in;
    logic [7:0]  en_mask;
    logic [15:0] dwell;
    logic        hold;
    logic [63:0] din;
    logic [7:0]  o;
    logic [2:0]  o_sel;
    logic        o_valid;
    logic        tick;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic [7:0] o;
        logic [2:0] sel;
        logic       v;
        logic       t;
    } exp_t;

    exp_t exp_q[$];

    mux_scan_n #(
        .CH    (8),
        .W     (8),
        .SW    (3),
        .DIV_W (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .sel_in  (sel_in),
        .en_mask (en_mask),
        .dwell   (dwell),
        .hold    (hold),
        .din     (din),
        .o       (o),
        .o_sel   (o_sel),
        .o_valid (o_valid),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] chv(input int i);
        return 8'(16 + i);
    endfunction

    task automatic set_base();
        for (int i = 0; i < 8; i++) din[i*8 +: 8] = chv(i);
    endtask

    // Inputs are already driven; queue the outputs expected after the next edge.
    task automatic cyc(input string nm, input logic [7:0] eo, input logic [2:0] es,
                       input logic ev, input logic et);
        exp_t e;
        e.name = nm;
        e.o    = eo;
        e.sel  = es;
        e.v    = ev;
        e.t    = et;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (o !== e.o || o_sel !== e.sel || o_valid !== e.v || tick !== e.t) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got o=%h sel=%0d valid=%b tick=%b, want o=%h sel=%0d valid=%b tick=%b",
                             e.name, $time, o, o_sel, o_valid, tick, e.o, e.sel, e.v, e.t);
                end
            end
        end
    end

    initial begin : stim
        int wrap_seq[3] = '{7, 0, 1};
        int skip_seq[3] = '{2, 7, 0};

        rst_n   = 1'b0;
        mode    = 1'b0;
        sel_in  = 3'd0;
        en_mask = 8'hFF;
        dwell   = 16'd0;
        hold    = 1'b0;
        din     = {8{8'hFF}};
        cyc("reset0", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc("reset1", 8'h00, 3'd0, 1'b0, 1'b0);

        // Manual select.
        rst_n = 1'b1;
        set_base();
        sel_in = 3'd5;
        cyc("man_sel5", 8'h15, 3'd5, 1'b1, 1'b0);
        en_mask = 8'hDF;
        cyc("man_mask5", 8'h00, 3'd5, 1'b0, 1'b0);
        en_mask = 8'hFF;
        sel_in  = 3'd2;
        cyc("man_sel2", 8'h12, 3'd2, 1'b1, 1'b0);

        // Scan with wrap, dwell 3.
        sel_in = 3'd6;
        cyc("wrap_load", 8'h16, 3'd6, 1'b1, 1'b0);
        mode  = 1'b1;
        dwell = 16'd3;
        for (int i = 0; i < 3; i++) cyc("wrap_dwell6", 8'h16, 3'd6, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            cyc("wrap_adv", chv(wrap_seq[j]), 3'(wrap_seq[j]), 1'b1, 1'b1);
            for (int i = 0; i < 3; i++)
                cyc("wrap_dwell", chv(wrap_seq[j]), 3'(wrap_seq[j]), 1'b1, 1'b0);
        end

        // Mask skip, dwell 0.
        mode   = 1'b0;
        sel_in = 3'd0;
        cyc("skip_load", 8'h10, 3'd0, 1'b1, 1'b0);
        mode    = 1'b1;
        dwell   = 16'd0;
        en_mask = 8'h85;
        for (int r = 0; r < 2; r++)
            for (int j = 0; j < 3; j++)
                cyc("skip_adv", chv(skip_seq[j]), 3'(skip_seq[j]), 1'b1, 1'b1);
        en_mask = 8'h00;
        for (int i = 0; i < 3; i++) cyc("skip_none", 8'h00, 3'd0, 1'b0, 1'b0);
        en_mask = 8'h01;
        for (int i = 0; i < 2; i++) cyc("skip_single", 8'h10, 3'd0, 1'b1, 1'b0);

        // Hold, then dwell shrink below the count.
        mode    = 1'b0;
        sel_in  = 3'd3;
        en_mask = 8'hFF;
        cyc("hold_load", 8'h13, 3'd3, 1'b1, 1'b0);
        mode  = 1'b1;
        dwell = 16'd100;
        for (int i = 0; i < 50; i++) cyc("hold_run", 8'h13, 3'd3, 1'b1, 1'b0);
        hold  = 1'b1;
        dwell = 16'd0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) din[3*8 +: 8] = 8'h33;
            cyc("hold_frz", (i < 5) ? 8'h13 : 8'h33, 3'd3, 1'b1, 1'b0);
        end
        hold  = 1'b0;
        dwell = 16'd20;
        din[3*8 +: 8] = 8'h13;
        cyc("shrink_adv", 8'h14, 3'd4, 1'b1, 1'b1);

        // Reset in the middle of a dwell.
        mode   = 1'b0;
        sel_in = 3'd3;
        dwell  = 16'd3;
        cyc("rs_load", 8'h13, 3'd3, 1'b1, 1'b0);
        mode = 1'b1;
        for (int i = 0; i < 2; i++) cyc("rs_run", 8'h13, 3'd3, 1'b1, 1'b0);
        rst_n = 1'b0;
        cyc("rs_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc("rs_dwell0", 8'h10, 3'd0, 1'b1, 1'b0);
        cyc("rs_adv", 8'h11, 3'd1, 1'b1, 1'b1);

        // Back to manual: no tick even though dwell 0 would expire.
        mode   = 1'b0;
        dwell  = 16'd0;
        sel_in = 3'd5;
        cyc("to_manual", 8'h15, 3'd5, 1'b1, 1'b0);

        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
